// File: rtl/lm_sm_pkg.sv
// Shared types and default sizes for the LM/SM micro-sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lm_sm_pkg;

    localparam int NREGS  = 8;
    localparam int REG_AW = 3;
    localparam int DATA_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } state_t;

endpackage

// File: rtl/lm_sm_sequencer_lowest_set_enc.sv
// Finds the lowest set bit of a mask, plus empty and exactly-one-bit flags.
// Latency: purely combinational.
// Backpressure: none.
module lowest_set_enc #(
    parameter int NREGS = 8,
    parameter int IDX_W = 3
) (
    input  logic [NREGS-1:0] mask,
    output logic [IDX_W-1:0] idx,
    output logic             none,
    output logic             single
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IDX_W'(i);
            end
        end
        none   = (mask == '0);
        single = !none && ((mask & (mask - NREGS'(1))) == '0);
    end

endmodule

// File: rtl/lm_sm_sequencer.sv
// Expands one LM/SM register list into single-register micro-ops, lowest register first.
// Latency: first micro-op in the start cycle; one micro-op per unheld cycle after that.
// Backpressure: hold freezes everything; stall_upstream is high until the last micro-op issues.
module lm_sm_sequencer #(
    parameter int NREGS  = lm_sm_pkg::NREGS,
    parameter int REG_AW = lm_sm_pkg::REG_AW,
    parameter int DATA_W = lm_sm_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_valid,
    input  logic              is_lm,
    input  logic              is_sm,
    input  logic [REG_AW-1:0] base_reg,
    input  logic [NREGS-1:0]  reg_list,
    input  logic              hold,
    input  logic              flush,
    output logic              uop_valid,
    output logic              uop_is_lm,
    output logic [REG_AW-1:0] uop_base,
    output logic [REG_AW-1:0] uop_reg,
    output logic [DATA_W-1:0] uop_offset,
    output logic              uop_first,
    output logic              uop_last,
    output logic              stall_upstream,
    output logic              busy
);

    import lm_sm_pkg::*;

    state_t            state, state_nxt;
    logic [NREGS-1:0]  pending, pending_nxt;
    logic [REG_AW-1:0] count, count_nxt;
    logic              lm_q, lm_nxt;
    logic [REG_AW-1:0] base_q, base_nxt;

    logic [REG_AW-1:0] list_idx, pend_idx;
    logic              list_none, list_single;
    logic              pend_none, pend_single;
    logic [NREGS-1:0]  list_rest;
    logic              start;

    lowest_set_enc #(.NREGS(NREGS), .IDX_W(REG_AW)) u_list_enc (
        .mask   (reg_list),
        .idx    (list_idx),
        .none   (list_none),
        .single (list_single)
    );

    lowest_set_enc #(.NREGS(NREGS), .IDX_W(REG_AW)) u_pend_enc (
        .mask   (pending),
        .idx    (pend_idx),
        .none   (pend_none),
        .single (pend_single)
    );

    // Start qualification and the list with its lowest bit already consumed.
    always_comb begin
        start     = start_valid && (is_lm || is_sm) && !hold && !flush;
        list_rest = reg_list & (reg_list - NREGS'(1));
    end

    // Next-state and micro-op outputs; everything defaults to 0 so reset and flush need no extra branch.
    always_comb begin
        state_nxt      = state;
        pending_nxt    = pending;
        count_nxt      = count;
        lm_nxt         = lm_q;
        base_nxt       = base_q;
        uop_valid      = 1'b0;
        uop_is_lm      = 1'b0;
        uop_base       = '0;
        uop_reg        = '0;
        uop_offset     = '0;
        uop_first      = 1'b0;
        uop_last       = 1'b0;
        stall_upstream = 1'b0;
        busy           = reset && (state == SEQ);

        if (reset) begin
            if (flush) begin
                // Squash: drop the instruction, keep lm_q/base_q (they are don't-care in IDLE).
                state_nxt   = IDLE;
                pending_nxt = '0;
                count_nxt   = '0;
            end else if (state == SEQ) begin
                // Outputs are a pure function of the held state, so hold repeats them unchanged.
                uop_valid      = !pend_none;
                uop_is_lm      = lm_q;
                uop_base       = base_q;
                uop_reg        = pend_idx;
                uop_offset     = DATA_W'(count);
                uop_last       = pend_single;
                stall_upstream = !pend_single;
                if (!hold) begin
                    if (pend_single || pend_none) begin
                        state_nxt   = IDLE;
                        pending_nxt = '0;
                        count_nxt   = '0;
                    end else begin
                        pending_nxt = pending & (pending - NREGS'(1));
                        count_nxt   = count + REG_AW'(1);
                    end
                end
            end else if (start && !list_none) begin
                // First micro-op goes out combinationally; an LM/SM with both flags set loads.
                uop_valid      = 1'b1;
                uop_is_lm      = is_lm;
                uop_base       = base_reg;
                uop_reg        = list_idx;
                uop_first      = 1'b1;
                uop_last       = list_single;
                stall_upstream = !list_single;
                if (!list_single) begin
                    state_nxt   = SEQ;
                    pending_nxt = list_rest;
                    count_nxt   = REG_AW'(1);
                    lm_nxt      = is_lm;
                    base_nxt    = base_reg;
                end
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            pending <= '0;
            count   <= '0;
            lm_q    <= 1'b0;
            base_q  <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            count   <= count_nxt;
            lm_q    <= lm_nxt;
            base_q  <= base_nxt;
        end
    end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed bench for lm_sm_sequencer with a queue-based reference model checked every cycle.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: hold and flush are driven directly by the stimulus.
module tb_lm_sm_sequencer;

    logic        clock;
    logic        reset;
    logic        start_valid;
    logic        is_lm;
    logic        is_sm;
    logic [2:0]  base_reg;
    logic [7:0]  reg_list;
    logic        hold;
    logic        flush;
    logic        uop_valid;
    logic        uop_is_lm;
    logic [2:0]  uop_base;
    logic [2:0]  uop_reg;
    logic [15:0] uop_offset;
    logic        uop_first;
    logic        uop_last;
    logic        stall_upstream;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int rg;
        int off;
        int base;
        bit lm;
        bit first;
        bit last;
        bit stall;
    } ent_t;

    ent_t log_q[$];
    bit   any_stall;
    bit   any_busy;

    // Reference model state: registers still to transfer, next offset, latched type/base.
    int m_q[$];
    int m_off;
    bit m_lm;
    int m_base;

    lm_sm_sequencer #(.NREGS(8), .REG_AW(3), .DATA_W(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .start_valid    (start_valid),
        .is_lm          (is_lm),
        .is_sm          (is_sm),
        .base_reg       (base_reg),
        .reg_list       (reg_list),
        .hold           (hold),
        .flush          (flush),
        .uop_valid      (uop_valid),
        .uop_is_lm      (uop_is_lm),
        .uop_base       (uop_base),
        .uop_reg        (uop_reg),
        .uop_offset     (uop_offset),
        .uop_first      (uop_first),
        .uop_last       (uop_last),
        .stall_upstream (stall_upstream),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, then advance the model past the coming edge.
    always @(negedge clock) begin
        int tmp[$];
        bit e_vld, e_lm, e_first, e_last, e_stall, e_busy;
        int e_base, e_reg, e_off;
        e_vld = 0; e_lm = 0; e_first = 0; e_last = 0; e_stall = 0;
        e_base = 0; e_reg = 0; e_off = 0;
        e_busy = reset && (m_q.size() > 0);
        if (!reset) begin
            m_q.delete();
            m_off = 0;
        end else if (flush) begin
            m_q.delete();
            m_off = 0;
        end else if (m_q.size() > 0) begin
            e_vld = 1; e_lm = m_lm; e_base = m_base; e_reg = m_q[0]; e_off = m_off;
            e_last = (m_q.size() == 1); e_stall = (m_q.size() > 1);
            if (!hold) begin
                void'(m_q.pop_front());
                m_off++;
                if (m_q.size() == 0) m_off = 0;
            end
        end else if (start_valid && (is_lm || is_sm) && !hold && reg_list != 8'h00) begin
            tmp.delete();
            for (int i = 0; i < 8; i++) if (reg_list[i]) tmp.push_back(i);
            e_vld = 1; e_lm = is_lm; e_base = int'(base_reg); e_reg = tmp[0]; e_off = 0;
            e_first = 1; e_last = (tmp.size() == 1); e_stall = (tmp.size() > 1);
            void'(tmp.pop_front());
            m_q = tmp;
            m_off = (tmp.size() > 0) ? 1 : 0;
            m_lm = is_lm;
            m_base = int'(base_reg);
        end
        chk("uop_valid", 32'(uop_valid), 32'(e_vld));
        chk("uop_is_lm", 32'(uop_is_lm), 32'(e_lm));
        chk("uop_base", 32'(uop_base), e_base);
        chk("uop_reg", 32'(uop_reg), e_reg);
        chk("uop_offset", 32'(uop_offset), e_off);
        chk("uop_first", 32'(uop_first), 32'(e_first));
        chk("uop_last", 32'(uop_last), 32'(e_last));
        chk("stall_upstream", 32'(stall_upstream), 32'(e_stall));
        chk("busy", 32'(busy), 32'(e_busy));
        if (uop_valid === 1'b1)
            log_q.push_back('{rg: int'(uop_reg), off: int'(uop_offset), base: int'(uop_base),
                              lm: uop_is_lm, first: uop_first, last: uop_last, stall: stall_upstream});
        if (stall_upstream === 1'b1) any_stall = 1;
        if (busy === 1'b1) any_busy = 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_log();
        log_q.delete();
        any_stall = 0;
        any_busy  = 0;
    endtask

    // Present one instruction for a single cycle, then withdraw it.
    task automatic issue(input bit lm, input bit sm, input logic [2:0] base, input logic [7:0] list);
        start_valid = 1; is_lm = lm; is_sm = sm; base_reg = base; reg_list = list;
        tick(1);
        start_valid = 0; is_lm = 0; is_sm = 0; base_reg = 0; reg_list = 0;
    endtask

    initial begin
        int exp_regs[4];
        int exp_offs[10];
        int n3;
        exp_regs = '{0, 2, 5, 7};
        exp_offs = '{0, 1, 2, 3, 3, 3, 4, 5, 6, 7};
        m_off = 0; m_lm = 0; m_base = 0;
        reset = 0; start_valid = 0; is_lm = 0; is_sm = 0;
        base_reg = 0; reg_list = 0; hold = 0; flush = 0;
        clear_log();

        // Reset, with a start request present that must be ignored.
        start_valid = 1; is_lm = 1; reg_list = 8'hFF;
        @(negedge clock);
        chk("reset_valid", 32'(uop_valid), 0);
        chk("reset_busy", 32'(busy), 0);
        tick(2);
        start_valid = 0; is_lm = 0; reg_list = 0;
        reset = 1;
        tick(1);

        // LM, base R6, list 1010_0101.
        clear_log();
        issue(1, 0, 3'd6, 8'hA5);
        tick(5);
        chk("a5_count", log_q.size(), 4);
        if (log_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("a5_reg", log_q[i].rg, exp_regs[i]);
                chk("a5_off", log_q[i].off, i);
                chk("a5_base", log_q[i].base, 6);
                chk("a5_first", 32'(log_q[i].first), (i == 0) ? 1 : 0);
                chk("a5_last", 32'(log_q[i].last), (i == 3) ? 1 : 0);
                chk("a5_stall", 32'(log_q[i].stall), (i < 3) ? 1 : 0);
            end
        end

        // SM with an empty list is a no-op.
        clear_log();
        issue(0, 1, 3'd2, 8'h00);
        tick(3);
        chk("empty_count", log_q.size(), 0);
        chk("empty_stall", 32'(any_stall), 0);
        chk("empty_busy", 32'(any_busy), 0);

        // SM with a single bit: one micro-op, first and last together.
        clear_log();
        issue(0, 1, 3'd1, 8'h80);
        tick(3);
        chk("single_count", log_q.size(), 1);
        if (log_q.size() == 1) begin
            chk("single_reg", log_q[0].rg, 7);
            chk("single_off", log_q[0].off, 0);
            chk("single_first", 32'(log_q[0].first), 1);
            chk("single_last", 32'(log_q[0].last), 1);
            chk("single_stall", 32'(log_q[0].stall), 0);
            chk("single_lm", 32'(log_q[0].lm), 0);
        end
        chk("single_busy", 32'(any_busy), 0);

        // LM 0xFF with hold for two cycles while reg 3 is presented.
        clear_log();
        issue(1, 0, 3'd4, 8'hFF);
        tick(2);
        hold = 1;
        tick(2);
        hold = 0;
        tick(8);
        chk("hold_count", log_q.size(), 10);
        n3 = 0;
        foreach (log_q[i]) if (log_q[i].rg == 3) n3++;
        chk("hold_reg3", n3, 3);
        if (log_q.size() == 10) begin
            for (int i = 0; i < 10; i++) chk("hold_off", log_q[i].off, exp_offs[i]);
            chk("hold_last", 32'(log_q[9].last), 1);
        end

        // LM 0x0F flushed on its second micro-op, then a fresh SM.
        issue(1, 0, 3'd5, 8'h0F);
        flush = 1;
        @(negedge clock);
        chk("flush_valid", 32'(uop_valid), 0);
        chk("flush_stall", 32'(stall_upstream), 0);
        tick(1);
        flush = 0;
        @(negedge clock);
        chk("flush_idle", 32'(busy), 0);
        tick(1);
        clear_log();
        issue(0, 1, 3'd3, 8'h01);
        tick(2);
        chk("after_flush_count", log_q.size(), 1);
        if (log_q.size() == 1) begin
            chk("after_flush_reg", log_q[0].rg, 0);
            chk("after_flush_off", log_q[0].off, 0);
        end

        // Reset during the third micro-op of 0xFF.
        issue(1, 0, 3'd7, 8'hFF);
        tick(1);
        reset = 0;
        @(negedge clock);
        chk("rst_seq_valid", 32'(uop_valid), 0);
        chk("rst_seq_stall", 32'(stall_upstream), 0);
        chk("rst_seq_reg", 32'(uop_reg), 0);
        tick(1);
        reset = 1;
        @(negedge clock);
        chk("rst_seq_idle", 32'(busy), 0);
        tick(1);
        clear_log();
        issue(0, 1, 3'd2, 8'h06);
        tick(3);
        chk("post_rst_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("post_rst_off0", log_q[0].off, 0);
            chk("post_rst_reg0", log_q[0].rg, 1);
            chk("post_rst_off1", log_q[1].off, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lm_sm_sequencer.md
# lm_sm_sequencer

Register-read-stage micro-sequencer for the load-multiple (LM) and store-multiple (SM) instructions. It expands one LM/SM with an 8-bit register list into one single-register micro-op per set bit, lowest register first. It drives the micro-op fields that feed the RF/EX pipeline register, and stalls the upstream stages until the last micro-op has issued.

## Interface
Parameters:
- `NREGS`, default 8: register-list width and register-file depth.
- `REG_AW`, default 3: register address width, equal to log2(`NREGS`).
- `DATA_W`, default 16: datapath width; sets the width of `uop_offset`.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low; 0 = reset.
- `start_valid`  in  1  valid instruction present in the RR stage.
- `is_lm`  in  1  instruction is LM.
- `is_sm`  in  1  instruction is SM.
- `base_reg`  in  `REG_AW`  RA field, the address base register.
- `reg_list`  in  `NREGS`  imm8 register list.
- `hold`  in  1  downstream stall; freezes the block.
- `flush`  in  1  squash from branch/jump resolution.
- `uop_valid`  out  1  a micro-op is presented this cycle.
- `uop_is_lm`  out  1  1 = load micro-op (uop_reg is the destination); 0 = store (uop_reg is the source).
- `uop_base`  out  `REG_AW`  base register of the instruction.
- `uop_reg`  out  `REG_AW`  register transferred by this micro-op.
- `uop_offset`  out  `DATA_W`  zero-extended transfer index, 0..7; EX computes the address as RA + offset.
- `uop_first`  out  1  first micro-op of the instruction.
- `uop_last`  out  1  last micro-op of the instruction.
- `stall_upstream`  out  1  hold the PC and the IF/ID and ID/RR registers.
- `busy`  out  1  state is SEQ.

## Operation
- State: `IDLE`, `SEQ`. Registers:
  - `pending[NREGS-1:0]`: list bits not yet issued.
  - `count[REG_AW-1:0]`: index of the next transfer.
  - `lm_q`: latched LM/SM type.
  - `base_q`: latched base register.
- Start condition: `start_valid & (is_lm | is_sm) & !hold & !flush`, evaluated in IDLE. If both `is_lm` and `is_sm` are 1, the instruction is treated as LM.
- Start cycle (combinational from the inputs):
  - `uop_reg` = lowest set bit of `reg_list`; `uop_offset` = 0; `uop_first` = 1.
  - `uop_valid` = 1 if `reg_list` is non-zero.
  - Rest = `reg_list` with the lowest set bit cleared.
  - If rest ≠ 0: capture `pending` = rest, `count` = 1, latch type and base, go to SEQ. `stall_upstream` = 1 in this cycle.
  - If rest = 0: `uop_last` = 1, stay in IDLE, no stall.
- Empty list (`reg_list` = 0): no micro-op, `uop_valid` = 0, no stall, stay in IDLE. The instruction completes as a no-op.
- SEQ cycle:
  - `uop_reg` = lowest set bit of `pending`; `uop_offset` = `count`; `uop_base` = `base_q`; `uop_is_lm` = `lm_q`; `uop_first` = 0.
  - If `pending` holds exactly one bit: `uop_last` = 1, `stall_upstream` = 0, next state IDLE.
  - Otherwise: `stall_upstream` = 1; on the edge, clear that bit and increment `count`.
- `hold` = 1: no state change. Outputs keep their values; `stall_upstream` keeps its value.
- `flush` = 1 (ignores `hold`):
  - `uop_valid` = 0 and `stall_upstream` = 0 in the same cycle.
  - Next state IDLE; `pending` and `count` are cleared.
- Priority: `reset` > `flush` > `hold` > normal operation.
- `start_valid` is ignored while in SEQ; upstream is held then anyway.
- Outside IDLE-start and SEQ cycles, all micro-op outputs are 0.

## Timing
- Reset (`reset` = 0): all outputs are forced to 0 in the same cycle. After the edge: state IDLE, `pending` = 0, `count` = 0, `lm_q` = 0, `base_q` = 0.
- Latency: the first micro-op appears in the start cycle (0 cycles).
- An N-bit list (N ≥ 1) issues one micro-op per unheld cycle: N cycles total, with `stall_upstream` high for the first N−1 cycles.
- `uop_offset` counts 0..N−1 and never wraps; the maximum is 7.
- `busy` is registered: it rises one cycle after a start with N ≥ 2 and falls on the edge after `uop_last`.
- A new start is legal in the cycle right after `uop_last`.
- Reset while in SEQ: outputs go to 0 immediately and the state is IDLE after the edge; the interrupted instruction is dropped.

## Structure
- Package `lm_sm_pkg`:
  - state enum `{IDLE, SEQ}`;
  - constants `NREGS`, `REG_AW`, `DATA_W`.
- Sub-module `lowest_set_enc` (combinational):
  - in: `NREGS` mask;
  - out: index of the lowest set bit, a `none` flag, and a `single` flag (exactly one bit set).
  - Instantiated twice: once on `reg_list`, once on `pending`.

## Test plan
- LM, base R6, list 8'b1010_0101:
  - `uop_reg` 0, 2, 5, 7 with `uop_offset` 0, 1, 2, 3;
  - `uop_first` on cycle 1, `uop_last` on cycle 4;
  - `stall_upstream` high on cycles 1–3 only; `uop_base` = 6 throughout.
- SM, list 8'h00: `uop_valid` stays 0, no stall, `busy` stays 0.
- SM, list 8'h80: one cycle with `uop_reg` = 7, offset 0, `uop_first` = `uop_last` = 1, `stall_upstream` = 0.
- LM, list 8'hFF, `hold` high for 2 cycles while `uop_reg` = 3: reg 3 is presented for 3 cycles, sequence ends after 10 cycles, offsets 0..7 with no gaps.
- LM, list 8'h0F, `flush` on the second micro-op:
  - `uop_valid` = 0 and `stall_upstream` = 0 in that cycle;
  - IDLE next cycle;
  - a following SM with list 8'h01 issues reg 0, offset 0.
- `reset` low during the third micro-op of list 8'hFF: all outputs 0 that cycle, IDLE and `count` = 0 after the edge.
